muldiv_issue_ctrl: RTL

Sequencer that sits between the EXE stage and the shared Booth/Wallace multiplier and iterative divider units. It accepts one mul/div request at a time and latches the operands. It then launches exactly one unit and waits for that unit's out_valid. The result is held until EXE/MEM accepts it. It also owns flush propagation to both units and a watchdog that aborts a hung unit.

---
 rtl/muldiv_issue_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/muldiv_issue_ctrl.sv
// Issue sequencer between EXE and the shared multiplier / divider units.
// Accepts one op, launches one unit, holds the result until consumed; owns flush and watchdog.
module muldiv_issue_ctrl #(
  parameter int unsigned MAX_LAT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic             req_sign,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic             flush,
  output logic             mul_in_valid,
  output logic             div_in_valid,
  output logic             unit_sign,
  output logic [31:0]      unit_src1,
  output logic [31:0]      unit_src2,
  output logic             unit_flush,
  input  logic             mul_out_valid,
  input  logic [31:0]      mul_hi,
  input  logic [31:0]      mul_lo,
  input  logic             div_out_valid,
  input  logic [31:0]      quotient,
  input  logic [31:0]      remainder,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] last_lat
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t           state;
  logic [3:0]       op;
  logic [CNT_W-1:0] cnt;

  logic        accept;
  logic        in_wait;
  logic        unit_hit;
  logic        wd_fire;
  logic [31:0] unit_result;

  always_comb begin
    accept   = (state == IDLE) && req_valid && !flush && $onehot(req_op);
    in_wait  = (state == MUL_WAIT) || (state == DIV_WAIT);
    // Only the launched unit's completion counts; the other unit's pulses are stale.
    unit_hit = ((state == MUL_WAIT) && mul_out_valid) ||
               ((state == DIV_WAIT) && div_out_valid);
    wd_fire  = in_wait && !unit_hit && (cnt == CNT_W'(MAX_LAT - 1));
  end

  always_comb begin
    if (op[0])      unit_result = mul_lo;
    else if (op[2]) unit_result = mul_hi;
    else if (op[3]) unit_result = quotient;
    else            unit_result = remainder;
  end

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign res_valid    = (state == DONE);
  assign mul_in_valid = (state == MUL_WAIT);
  assign div_in_valid = (state == DIV_WAIT);
  assign timeout      = wd_fire;
  assign unit_flush   = flush | wd_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= '0;
      cnt       <= '0;
      unit_sign <= 1'b0;
      unit_src1 <= '0;
      unit_src2 <= '0;
      res_data  <= '0;
      last_lat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op        <= req_op;
            unit_sign <= req_sign;
            unit_src1 <= req_src1;
            unit_src2 <= req_src2;
            cnt       <= '0;
            if (req_op[0] || req_op[2]) begin
              state <= MUL_WAIT;
            end else if (req_src2 == '0) begin
              // Divide by zero resolves locally; the divider is never launched.
              res_data <= '0;
              state    <= DONE;
            end else begin
              state <= DIV_WAIT;
            end
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          cnt <= cnt + 1'b1;
          if (flush || wd_fire) begin
            state <= IDLE;
          end else if (unit_hit) begin
            res_data <= unit_result;
            last_lat <= cnt + 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (flush || res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
